tinyqv_instr_prefetch: RTL and testbench

Parametrised instruction prefetch queue for the TinyQV CPU. Accepts 16-bit halfwords from the QSPI instruction fetch port into a circular buffer of configurable depth, and presents the next RV32IC instruction (16- or 32-bit) to the decoder. Tracks the PC, throttles the fetcher when the buffer is full, and flushes/redirects on branch. Successor to the fixed 4-halfword fetch buffer: depth, address width and reset vector are generalised; it adds explicit length/valid reporting and an occupancy output.

---
 rtl/tinyqv_instr_prefetch_pkg.sv | 12 +
 rtl/tinyqv_instr_prefetch.sv | 90 +++++++++
 tb/tb_tinyqv_instr_prefetch.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tinyqv_instr_prefetch_pkg.sv
// Shared encodings for the TinyQV instruction prefetch queue.
package tinyqv_instr_prefetch_pkg;

  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_32 = 2'b10;

  // RV32IC: low bits 2'b11 mark a full-width instruction, anything else is compressed.
  function automatic logic [1:0] instr_len_of(input logic [1:0] lsb);
    return (lsb == 2'b11) ? LEN_32 : LEN_16;
  endfunction

endpackage

// File: rtl/tinyqv_instr_prefetch.sv
// Halfword prefetch queue between the QSPI fetcher and the RV32IC decoder.
// Tracks the PC of the oldest buffered instruction and throttles/redirects the fetcher.
module tinyqv_instr_prefetch
  import tinyqv_instr_prefetch_pkg::*;
#(
  parameter int                    DEPTH      = 4,
  parameter int                    ADDR_BITS  = 24,
  parameter logic [ADDR_BITS-1:0]  RESET_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rstn,
  output logic [ADDR_BITS-1:1]     instr_addr,
  output logic                     instr_fetch_restart,
  output logic                     instr_fetch_stall,
  input  logic                     instr_fetch_started,
  input  logic                     instr_fetch_stopped,
  input  logic [15:0]              instr_data_in,
  input  logic                     instr_ready,
  input  logic                     branch,
  input  logic [ADDR_BITS-1:1]     branch_addr,
  input  logic                     consume,
  output logic [31:0]              instr_out,
  output logic [1:0]               instr_len,
  output logic                     instr_valid,
  output logic [ADDR_BITS-1:1]     pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam logic [PTR_BITS:0] FULL = (PTR_BITS+1)'(DEPTH);

  logic [15:0]         hw_mem [DEPTH];
  logic [PTR_BITS:0]   rd_ptr;
  logic [PTR_BITS:0]   wr_ptr;
  logic                fetch_running;

  logic [PTR_BITS-1:0] rd_idx;
  logic [PTR_BITS-1:0] rd_idx_nxt;
  logic                wr_en;
  logic                cons_en;
  logic [PTR_BITS:0]   cons_amt;
  logic [PTR_BITS:0]   next_occ;

  assign rd_idx     = rd_ptr[PTR_BITS-1:0];
  assign rd_idx_nxt = rd_idx + 1'b1;
  assign occupancy  = wr_ptr - rd_ptr;

  assign instr_out   = {hw_mem[rd_idx_nxt], hw_mem[rd_idx]};
  assign instr_len   = instr_len_of(hw_mem[rd_idx][1:0]);
  // Storage is never reset, so an empty queue must mask whatever the stale slot decodes to.
  assign instr_valid = (occupancy != '0) &&
                       (occupancy >= {{(PTR_BITS-1){1'b0}}, instr_len});

  assign wr_en    = instr_ready && fetch_running && (occupancy < FULL) && !branch;
  assign cons_en  = consume && instr_valid && !branch;
  assign cons_amt = cons_en ? {{(PTR_BITS-1){1'b0}}, instr_len} : '0;
  assign next_occ = branch ? '0 : occupancy + {{PTR_BITS{1'b0}}, wr_en} - cons_amt;

  // Warn one cycle ahead so the halfword already in flight still has a slot.
  assign instr_fetch_stall   = (next_occ == FULL);
  assign instr_fetch_restart = !fetch_running && !branch;
  assign instr_addr = pc + {{(ADDR_BITS-2-PTR_BITS){1'b0}}, occupancy};

  always_ff @(posedge clk) begin
    if (wr_en) hw_mem[wr_ptr[PTR_BITS-1:0]] <= instr_data_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      pc            <= RESET_ADDR[ADDR_BITS-1:1];
      fetch_running <= 1'b0;
    end else if (branch) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      pc            <= branch_addr;
      fetch_running <= 1'b0;
    end else begin
      if (instr_fetch_started)      fetch_running <= 1'b1;
      else if (instr_fetch_stopped) fetch_running <= 1'b0;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (cons_en) begin
        rd_ptr <= rd_ptr + cons_amt;
        pc     <= pc + {{(ADDR_BITS-3){1'b0}}, instr_len};
      end
    end
  end

endmodule

// File: tb/tb_tinyqv_instr_prefetch.sv
// Scoreboard bench for tinyqv_instr_prefetch (DEPTH=8, RESET_ADDR=0x100).
module tb_tinyqv_instr_prefetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic [22:0] instr_addr;
  logic        instr_fetch_restart;
  logic        instr_fetch_stall;
  logic        instr_fetch_started;
  logic        instr_fetch_stopped;
  logic [15:0] instr_data_in;
  logic        instr_ready;
  logic        branch;
  logic [22:0] branch_addr;
  logic        consume;
  logic [31:0] instr_out;
  logic [1:0]  instr_len;
  logic        instr_valid;
  logic [22:0] pc;
  logic [3:0]  occupancy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  len;
    logic [22:0] pc;
  } sb_t;

  sb_t         sb_q[$];
  logic [15:0] hw_q[$];
  logic [22:0] m_pc;

  tinyqv_instr_prefetch #(
    .DEPTH(8),
    .ADDR_BITS(24),
    .RESET_ADDR(24'h000100)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .instr_addr(instr_addr),
    .instr_fetch_restart(instr_fetch_restart),
    .instr_fetch_stall(instr_fetch_stall),
    .instr_fetch_started(instr_fetch_started),
    .instr_fetch_stopped(instr_fetch_stopped),
    .instr_data_in(instr_data_in),
    .instr_ready(instr_ready),
    .branch(branch),
    .branch_addr(branch_addr),
    .consume(consume),
    .instr_out(instr_out),
    .instr_len(instr_len),
    .instr_valid(instr_valid),
    .pc(pc),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Assemble fetched halfwords into whole instructions and queue them with their PC.
  task automatic sb_push_hw(input logic [15:0] hw);
    sb_t e;
    hw_q.push_back(hw);
    while (hw_q.size() > 0) begin
      if (hw_q[0][1:0] != 2'b11) begin
        e.instr = {16'h0000, hw_q[0]};
        e.len   = 2'b01;
        e.pc    = m_pc;
        sb_q.push_back(e);
        m_pc = m_pc + 23'd1;
        void'(hw_q.pop_front());
      end else if (hw_q.size() >= 2) begin
        e.instr = {hw_q[1], hw_q[0]};
        e.len   = 2'b10;
        e.pc    = m_pc;
        sb_q.push_back(e);
        m_pc = m_pc + 23'd2;
        void'(hw_q.pop_front());
        void'(hw_q.pop_front());
      end else begin
        break;
      end
    end
  endtask

  task automatic consume_one(input string nm);
    sb_t e;
    int  w = 0;
    while (!instr_valid && w < 20) begin
      step();
      w++;
    end
    total++;
    if (!instr_valid || sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s_ready valid=%0b queued=%0d want valid=1 with queued>0", nm, instr_valid, sb_q.size());
      return;
    end
    e = sb_q.pop_front();
    total++;
    if (instr_len !== e.len) begin
      bad++;
      $display("FAIL %s_len got=%b exp=%b", nm, instr_len, e.len);
    end
    total++;
    if ((e.len == 2'b01 && instr_out[15:0] !== e.instr[15:0]) ||
        (e.len == 2'b10 && instr_out !== e.instr)) begin
      bad++;
      $display("FAIL %s_instr got=%h exp=%h", nm, instr_out, e.instr);
    end
    total++;
    if (pc !== e.pc) begin
      bad++;
      $display("FAIL %s_pc got=%h exp=%h", nm, pc, e.pc);
    end
    consume = 1'b1;
    step();
    consume = 1'b0;
    #1;
  endtask

  task automatic check_idle_reset(input string nm);
    total++;
    if (pc !== 23'h80 || instr_addr !== 23'h80) begin
      bad++;
      $display("FAIL %s_pc got pc=%h addr=%h exp=80/80", nm, pc, instr_addr);
    end
    total++;
    if (instr_fetch_restart !== 1'b1 || instr_valid !== 1'b0 || instr_fetch_stall !== 1'b0) begin
      bad++;
      $display("FAIL %s_ctl got restart=%b valid=%b stall=%b exp=1/0/0", nm,
               instr_fetch_restart, instr_valid, instr_fetch_stall);
    end
    total++;
    if (occupancy !== 4'd0) begin
      bad++;
      $display("FAIL %s_occ got=%0d exp=0", nm, occupancy);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    instr_fetch_started = 1'b0;
    instr_fetch_stopped = 1'b0;
    instr_data_in = 16'h0;
    instr_ready = 1'b0;
    branch = 1'b0;
    branch_addr = '0;
    consume = 1'b0;
    #12;
    check_idle_reset("reset");
    @(negedge clk);
    rstn = 1'b1;
    #1;
    m_pc = 23'h80;
    sb_q.delete();
    hw_q.delete();
    step();
    check_idle_reset("post_reset");
  endtask

  task automatic start_fetch(input string nm);
    instr_fetch_started = 1'b1;
    step();
    instr_fetch_started = 1'b0;
    #1;
    total++;
    if (instr_fetch_restart !== 1'b0) begin
      bad++;
      $display("FAIL %s_restart got=%b exp=0", nm, instr_fetch_restart);
    end
  endtask

  task automatic test_16bit();
    start_fetch("c16");
    instr_ready = 1'b1;
    instr_data_in = 16'h0001; sb_push_hw(16'h0001); step();
    instr_data_in = 16'h4501; sb_push_hw(16'h4501); step();
    instr_ready = 1'b0;
    #1;
    total++;
    if (occupancy !== 4'd2 || instr_addr !== 23'h82) begin
      bad++;
      $display("FAIL c16_fill got occ=%0d addr=%h exp=2/82", occupancy, instr_addr);
    end
    consume_one("c16_a");
    consume_one("c16_b");
    total++;
    if (pc !== 23'h82 || occupancy !== 4'd0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL c16_end got pc=%h occ=%0d valid=%b exp=82/0/0", pc, occupancy, instr_valid);
    end
  endtask

  task automatic test_32bit();
    instr_ready = 1'b1;
    instr_data_in = 16'h0513; sb_push_hw(16'h0513); step();
    instr_ready = 1'b0;
    #1;
    total++;
    if (occupancy !== 4'd1 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL i32_half got occ=%0d valid=%b exp=1/0", occupancy, instr_valid);
    end
    instr_ready = 1'b1;
    instr_data_in = 16'h0000; sb_push_hw(16'h0000); step();
    instr_ready = 1'b0;
    #1;
    total++;
    if (occupancy !== 4'd2 || instr_valid !== 1'b1 || instr_out !== 32'h00000513 || instr_len !== 2'b10) begin
      bad++;
      $display("FAIL i32_full got occ=%0d valid=%b out=%h len=%b exp=2/1/00000513/10",
               occupancy, instr_valid, instr_out, instr_len);
    end
    consume_one("i32");
    total++;
    if (pc !== 23'h84) begin
      bad++;
      $display("FAIL i32_pc got=%h exp=84", pc);
    end
  endtask

  task automatic test_full_stall();
    int occ = 0;
    logic [15:0] d;
    for (int i = 0; i < 11; i++) begin
      d = 16'h1001 + 16'(i << 2);
      instr_ready = 1'b1;
      instr_data_in = d;
      #1;
      total++;
      if (occupancy !== 4'(occ) || instr_fetch_stall !== (occ >= 7)) begin
        bad++;
        $display("FAIL fill_%0d got occ=%0d stall=%b exp=%0d/%b", i, occupancy, instr_fetch_stall, occ, occ >= 7);
      end
      if (occ < 8) begin
        sb_push_hw(d);
        occ++;
      end
      step();
    end
    instr_ready = 1'b0;
    #1;
    total++;
    if (occupancy !== 4'd8 || instr_fetch_stall !== 1'b1 || instr_addr !== 23'h8c) begin
      bad++;
      $display("FAIL full got occ=%0d stall=%b addr=%h exp=8/1/8c", occupancy, instr_fetch_stall, instr_addr);
    end
    consume = 1'b1;
    #1;
    total++;
    if (instr_fetch_stall !== 1'b0) begin
      bad++;
      $display("FAIL full_drain_stall got=%b exp=0", instr_fetch_stall);
    end
    consume = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) consume_one($sformatf("drain_%0d", i));
    total++;
    if (pc !== 23'h8c || occupancy !== 4'd0) begin
      bad++;
      $display("FAIL drain_end got pc=%h occ=%0d exp=8c/0", pc, occupancy);
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 5; i++) begin
      instr_ready = 1'b1;
      instr_data_in = 16'h2001;
      step();
    end
    #1;
    total++;
    if (occupancy !== 4'd5) begin
      bad++;
      $display("FAIL br_pre_occ got=%0d exp=5", occupancy);
    end
    branch = 1'b1;
    branch_addr = 23'h100;
    #1;
    total++;
    if (instr_fetch_restart !== 1'b0) begin
      bad++;
      $display("FAIL br_restart_low got=%b exp=0", instr_fetch_restart);
    end
    step();
    branch = 1'b0;
    instr_ready = 1'b0;
    m_pc = 23'h100;
    sb_q.delete();
    hw_q.delete();
    #1;
    total++;
    if (occupancy !== 4'd0 || pc !== 23'h100 || instr_addr !== 23'h100 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL br_after got occ=%0d pc=%h addr=%h valid=%b exp=0/100/100/0",
               occupancy, pc, instr_addr, instr_valid);
    end
    step();
    step();
    total++;
    if (instr_fetch_restart !== 1'b1) begin
      bad++;
      $display("FAIL br_restart_hold got=%b exp=1", instr_fetch_restart);
    end
    start_fetch("br");
    instr_ready = 1'b1;
    instr_data_in = 16'h4501; sb_push_hw(16'h4501); step();
    instr_ready = 1'b0;
    #1;
    consume_one("br_tgt");
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b1;
    instr_data_in = 16'h0001; sb_push_hw(16'h0001); step();
    instr_data_in = 16'h0002; sb_push_hw(16'h0002); step();
    instr_ready = 1'b0;
    #1;
    total++;
    if (occupancy !== 4'd2) begin
      bad++;
      $display("FAIL ar_pre_occ got=%0d exp=2", occupancy);
    end
    #1;
    rstn = 1'b0;
    #1;
    check_idle_reset("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    m_pc = 23'h80;
    sb_q.delete();
    hw_q.delete();
    #1;
    check_idle_reset("async_rel");
  endtask

  initial begin
    test_reset();
    test_16bit();
    test_32bit();
    test_full_stall();
    test_branch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
